// File: rtl/ldtu_baseline_calc.sv
// Baseline (pedestal) estimator for one ADC gain channel: on request it averages
// 2^LOG2_NSAMP accepted raw samples and publishes the rounded, clamped mean.
module ldtu_baseline_calc #(
  parameter int Nbits_12   = 12,
  parameter int Nbits_8    = 8,
  parameter int LOG2_NSAMP = 4
) (
  input  logic                DCLK_1,
  input  logic                rst_b,
  input  logic [Nbits_12-1:0] DATA12,
  input  logic                calib_start,
  input  logic [Nbits_12-1:0] reject_thr,
  input  logic [7:0]          max_reject,
  output logic [Nbits_8-1:0]  BSL_VAL,
  output logic                bsl_valid,
  output logic                bsl_sat,
  output logic                calib_busy,
  output logic                calib_done,
  output logic                calib_fail
);

  localparam int AW = Nbits_12 + LOG2_NSAMP + 1;
  localparam int CW = LOG2_NSAMP + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_NSAMP) - 1);
  localparam logic [AW-1:0] HALF = AW'(1 << (LOG2_NSAMP - 1));
  localparam logic [AW-1:0] MAXV = AW'((1 << Nbits_8) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE} state_t;

  state_t              state, state_nxt;
  logic [Nbits_12-1:0] d_reg;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       acc_cnt;
  logic [7:0]          rej_cnt;
  logic [Nbits_12-1:0] thr_q;
  logic [7:0]          mrej_q;
  logic                accept;
  logic                start_run, take, rej_inc, rej_fail, finish;

  // Round half up, then clamp to the output range; MSB of the result flags the clamp.
  function automatic logic [Nbits_8:0] round_sat(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = (a + HALF) >> LOG2_NSAMP;
    if (m > MAXV) round_sat = {1'b1, {Nbits_8{1'b1}}};
    else          round_sat = {1'b0, m[Nbits_8-1:0]};
  endfunction

  assign accept = (d_reg <= thr_q);

  always_ff @(posedge DCLK_1) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (calib_start) state_nxt = ACCUM;
      ACCUM: begin
        if (accept) begin
          if (acc_cnt == LAST) state_nxt = COMPUTE;
        end else if (rej_cnt == mrej_q) begin
          state_nxt = IDLE;
        end
      end
      COMPUTE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_run = 1'b0;
    take      = 1'b0;
    rej_inc   = 1'b0;
    rej_fail  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:    start_run = calib_start;
      ACCUM: begin
        take     = accept;
        rej_fail = !accept && (rej_cnt == mrej_q);
        rej_inc  = !accept && (rej_cnt != mrej_q);
      end
      COMPUTE: finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge DCLK_1) begin
    if (!rst_b) begin
      d_reg      <= '0;
      acc        <= '0;
      acc_cnt    <= '0;
      rej_cnt    <= '0;
      thr_q      <= '0;
      mrej_q     <= '0;
      BSL_VAL    <= '0;
      bsl_valid  <= 1'b0;
      bsl_sat    <= 1'b0;
      calib_busy <= 1'b0;
      calib_done <= 1'b0;
      calib_fail <= 1'b0;
    end else begin
      d_reg      <= DATA12;
      calib_done <= rej_fail | finish;
      if (start_run) begin
        acc        <= '0;
        acc_cnt    <= '0;
        rej_cnt    <= '0;
        thr_q      <= reject_thr;
        mrej_q     <= max_reject;
        calib_fail <= 1'b0;
        calib_busy <= 1'b1;
      end
      if (take) begin
        acc     <= acc + AW'(d_reg);
        acc_cnt <= acc_cnt + CW'(1);
      end
      if (rej_inc) rej_cnt <= rej_cnt + 8'd1;
      // A failed run leaves the previously published baseline untouched.
      if (rej_fail) begin
        calib_fail <= 1'b1;
        calib_busy <= 1'b0;
      end
      if (finish) begin
        {bsl_sat, BSL_VAL} <= round_sat(acc);
        bsl_valid          <= 1'b1;
        calib_busy         <= 1'b0;
      end
    end
  end

endmodule
